// File: rtl/sys_defs.sv
// ----------------------------------------------------------------------------
// sys_defs: shared types for the complete stage.
//   FU_COMPLETE_PACKET : result payload produced by a functional unit
//   FU_IDX             : functional-unit slot numbering used by the arbiter
//   lock_state_e       : grant-lock state of the completion arbiter
// ----------------------------------------------------------------------------
package sys_defs;

    typedef struct packed {
        logic [31:0] result;       // computed value / branch target
        logic [5:0]  dest_prn;     // destination physical register
        logic [4:0]  rob_idx;      // owning ROB entry
        logic        take_branch;  // branch resolved taken
    } FU_COMPLETE_PACKET;

    typedef enum logic [2:0] {
        FU_ALU_1  = 3'd0,
        FU_ALU_2  = 3'd1,
        FU_ALU_3  = 3'd2,
        FU_MULT_1 = 3'd3,
        FU_MULT_2 = 3'd4,
        FU_BRANCH = 3'd5
    } FU_IDX;

    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker: rotating-priority picker. Returns the first set request at or
// after i_ptr, wrapping from N-1 back to 0.
//   i_req : request vector
//   i_ptr : highest-priority index this cycle (must be < N)
//   o_idx : chosen index ('0 when nothing requested)
//   o_any : at least one request set
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 6,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic         w_hi_any;
    logic [W-1:0] w_hi_idx;
    logic         w_lo_any;
    logic [W-1:0] w_lo_idx;

    // Two priority searches: one over indices >= ptr, one over the whole
    // vector. The upper search wins; the lower covers the wrap-around case.
    // Scanning downward lets the lowest matching index overwrite last.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int m = N - 1; m >= 0; m--) begin
            if (i_req[m]) begin
                w_lo_any = 1'b1;
                w_lo_idx = W'(m);
                if (W'(m) >= i_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = W'(m);
                end
            end
        end
    end

    assign o_any = w_lo_any;
    assign o_idx = w_hi_any ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/complete_arbiter.sv
// ----------------------------------------------------------------------------
// complete_arbiter: collects finished results from NUM_FU functional units
// into one holding slot each and hands them to the complete stage one per
// cycle with round-robin priority.
//   clock, reset     : clock, asynchronous active-low reset
//   flush            : squash all held and incoming results
//   fu_req_in        : FU i presents a result this cycle
//   fu_packet_in     : per-FU result payload
//   fu_stall_out     : FU i must hold its result (slot busy)
//   complete_ready   : complete stage accepts a packet this cycle
//   complete_valid   : complete_out carries a packet
//   complete_out     : granted packet ('0 when not valid)
//   complete_fu_idx  : granted FU index ('0 when not valid)
//   occupancy_out    : number of full holding slots
// ----------------------------------------------------------------------------
module complete_arbiter
    import sys_defs::*;
#(
    parameter int NUM_FU = 6,
    parameter int IDX_W  = $clog2(NUM_FU)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_req_in,
    input  FU_COMPLETE_PACKET [NUM_FU-1:0]    fu_packet_in,
    output logic [NUM_FU-1:0]                 fu_stall_out,
    input  logic                              complete_ready,
    output logic                              complete_valid,
    output FU_COMPLETE_PACKET                 complete_out,
    output logic [IDX_W-1:0]                  complete_fu_idx,
    output logic [$clog2(NUM_FU+1)-1:0]       occupancy_out
);

    localparam int OCC_W = $clog2(NUM_FU + 1);

    logic [NUM_FU-1:0]              r_full;
    FU_COMPLETE_PACKET [NUM_FU-1:0] r_pkt;
    logic [IDX_W-1:0]               r_ptr;
    logic [IDX_W-1:0]               r_lock_idx;
    lock_state_e                    r_state;
    lock_state_e                    w_state_nxt;

    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_any;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_xfer;
    logic [NUM_FU-1:0] w_drain;
    logic [NUM_FU-1:0] w_load;
    logic [OCC_W-1:0]  w_occ;

    rr_picker #(
        .N (NUM_FU),
        .W (IDX_W)
    ) u_picker (
        .i_req (r_full),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_any)
    );

    // Once locked, the presented slot is frozen: it cannot drain without a
    // transfer and cannot reload because its stall stays high.
    assign w_gnt_idx       = (r_state == LK_LOCKED) ? r_lock_idx : w_pick_idx;
    assign complete_valid  = w_any & ~flush;
    assign complete_fu_idx = complete_valid ? w_gnt_idx : '0;
    assign complete_out    = complete_valid ? r_pkt[w_gnt_idx] : '0;
    assign w_xfer          = complete_valid & complete_ready;

    // A slot draining this cycle may accept a new result in the same cycle.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        assign w_drain[i]      = w_xfer & (w_gnt_idx == IDX_W'(i));
        assign fu_stall_out[i] = r_full[i] & ~w_drain[i];
        assign w_load[i]       = fu_req_in[i] & ~fu_stall_out[i] & ~flush;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_full[i] <= 1'b0;
                r_pkt[i]  <= '0;
            end else begin
                if (flush)
                    r_full[i] <= 1'b0;
                else if (w_load[i])
                    r_full[i] <= 1'b1;
                else if (w_drain[i])
                    r_full[i] <= 1'b0;
                if (w_load[i])
                    r_pkt[i] <= fu_packet_in[i];
            end
        end
    end

    // Round-robin pointer moves only on a transfer, so flush leaves it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Lock FSM: state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= LK_IDLE;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Tracks the pick while idle, holds itself while locked.
            r_lock_idx <= w_gnt_idx;
        end
    end

    // Lock FSM: next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LK_IDLE:   if (complete_valid && !complete_ready) w_state_nxt = LK_LOCKED;
            LK_LOCKED: if (w_xfer || flush)                   w_state_nxt = LK_IDLE;
            default:                                          w_state_nxt = LK_IDLE;
        endcase
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_FU; i++)
            w_occ = w_occ + OCC_W'(r_full[i]);
    end
    assign occupancy_out = w_occ;

endmodule

// File: tb/tb_complete_arbiter.sv
module tb_complete_arbiter;
    import sys_defs::*;

    localparam int NUM_FU = 6;
    localparam int IDX_W  = 3;
    localparam int OCC_W  = 3;

    logic                           clock = 1'b0;
    logic                           reset;
    logic                           flush;
    logic [NUM_FU-1:0]              fu_req_in;
    FU_COMPLETE_PACKET [NUM_FU-1:0] fu_packet_in;
    logic [NUM_FU-1:0]              fu_stall_out;
    logic                           complete_ready;
    logic                           complete_valid;
    FU_COMPLETE_PACKET              complete_out;
    logic [IDX_W-1:0]               complete_fu_idx;
    logic [OCC_W-1:0]               occupancy_out;

    complete_arbiter #(.NUM_FU(NUM_FU), .IDX_W(IDX_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .fu_req_in       (fu_req_in),
        .fu_packet_in    (fu_packet_in),
        .fu_stall_out    (fu_stall_out),
        .complete_ready  (complete_ready),
        .complete_valid  (complete_valid),
        .complete_out    (complete_out),
        .complete_fu_idx (complete_fu_idx),
        .occupancy_out   (occupancy_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        FU_COMPLETE_PACKET pkt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic FU_COMPLETE_PACKET mk(input int fu, input int tag);
        FU_COMPLETE_PACKET p;
        p.result      = 32'hC0DE_0000 | 32'(tag << 4) | 32'(fu);
        p.dest_prn    = 6'(tag + fu);
        p.rob_idx     = 5'(tag);
        p.take_branch = (fu == 5);
        return p;
    endfunction

    function automatic exp_t mkexp(input int fu, input int tag);
        exp_t e;
        e.idx = IDX_W'(fu);
        e.pkt = mk(fu, tag);
        return e;
    endfunction

    // Scoreboard: every accepted transfer must match the next expected grant.
    always @(negedge clock) begin
        if (reset === 1'b1 && complete_valid === 1'b1 && complete_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual idx=%0d pkt=%h required no transfer",
                         complete_fu_idx, complete_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (complete_fu_idx !== e.idx || complete_out !== e.pkt) begin
                    errors++;
                    $display("FAIL sb_grant actual idx=%0d pkt=%h required idx=%0d pkt=%h",
                             complete_fu_idx, complete_out, e.idx, e.pkt);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic clear_in();
        fu_req_in      = '0;
        fu_packet_in   = '0;
        flush          = 1'b0;
        complete_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_in();
        reset          = 1'b0;
        fu_req_in      = '1;
        complete_ready = 1'b1;
        smp();
        checks++; if (complete_valid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%0b required=0", complete_valid); end
        checks++; if (complete_out !== '0) begin errors++; $display("FAIL rst_out actual=%h required=0", complete_out); end
        checks++; if (complete_fu_idx !== '0) begin errors++; $display("FAIL rst_idx actual=%0d required=0", complete_fu_idx); end
        checks++; if (fu_stall_out !== '0) begin errors++; $display("FAIL rst_stall actual=%b required=000000", fu_stall_out); end
        checks++; if (occupancy_out !== '0) begin errors++; $display("FAIL rst_occ actual=%0d required=0", occupancy_out); end
        cyc();
        clear_in();
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        complete_ready  = 1'b1;
        fu_req_in       = 6'b000001;
        fu_packet_in[0] = mk(0, 1);
        exp_q.push_back(mkexp(0, 1));
        smp();
        checks++; if (complete_valid !== 1'b0) begin errors++; $display("FAIL single_nobypass actual=%0b required=0", complete_valid); end
        cyc();
        fu_req_in = '0;
        smp();
        checks++; if (complete_valid !== 1'b1) begin errors++; $display("FAIL single_valid actual=%0b required=1", complete_valid); end
        checks++; if (complete_fu_idx !== 3'd0) begin errors++; $display("FAIL single_idx actual=%0d required=0", complete_fu_idx); end
        checks++; if (fu_stall_out !== '0) begin errors++; $display("FAIL single_stall actual=%b required=000000", fu_stall_out); end
        cyc();
        smp();
        checks++; if (complete_valid !== 1'b0 || occupancy_out !== '0) begin errors++; $display("FAIL single_drain actual valid=%0b occ=%0d required valid=0 occ=0", complete_valid, occupancy_out); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_left actual=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_all_six();
        int stall5;
        stall5 = 0;
        do_reset();
        complete_ready = 1'b1;
        fu_req_in      = '1;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_packet_in[i] = mk(i, 2);
            exp_q.push_back(mkexp(i, 2));
        end
        smp();
        cyc();
        fu_req_in = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            smp();
            if (k == 0) begin
                checks++; if (occupancy_out !== 3'd6) begin errors++; $display("FAIL six_occ actual=%0d required=6", occupancy_out); end
            end
            checks++; if (complete_valid !== 1'b1 || complete_fu_idx !== IDX_W'(k)) begin errors++; $display("FAIL six_grant actual valid=%0b idx=%0d required valid=1 idx=%0d", complete_valid, complete_fu_idx, k); end
            stall5 += int'(fu_stall_out[5]);
            cyc();
        end
        smp();
        checks++; if (stall5 != 5) begin errors++; $display("FAIL six_stall5 actual=%0d required=5", stall5); end
        checks++; if (complete_valid !== 1'b0) begin errors++; $display("FAIL six_empty actual=%0b required=0", complete_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL six_left actual=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_lock();
        do_reset();
        fu_req_in       = 6'b000100;
        fu_packet_in[2] = mk(2, 3);
        exp_q.push_back(mkexp(2, 3));
        smp();
        cyc();
        fu_req_in       = 6'b000001;
        fu_packet_in[0] = mk(0, 4);
        exp_q.push_back(mkexp(0, 4));
        for (int r = 0; r < 3; r++) begin
            smp();
            checks++; if (complete_valid !== 1'b1 || complete_fu_idx !== 3'd2) begin errors++; $display("FAIL lock_idx actual valid=%0b idx=%0d required valid=1 idx=2", complete_valid, complete_fu_idx); end
            checks++; if (complete_out !== mk(2, 3)) begin errors++; $display("FAIL lock_pkt actual=%h required=%h", complete_out, mk(2, 3)); end
            cyc();
            fu_req_in = '0;
        end
        complete_ready = 1'b1;
        smp();
        checks++; if (complete_fu_idx !== 3'd2) begin errors++; $display("FAIL lock_release actual=%0d required=2", complete_fu_idx); end
        cyc();
        smp();
        checks++; if (complete_valid !== 1'b1 || complete_fu_idx !== 3'd0) begin errors++; $display("FAIL lock_wrap actual valid=%0b idx=%0d required valid=1 idx=0", complete_valid, complete_fu_idx); end
        cyc();
        smp();
        checks++; if (complete_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL lock_end actual valid=%0b left=%0d required valid=0 left=0", complete_valid, exp_q.size()); end
    endtask

    task automatic test_reload();
        do_reset();
        complete_ready  = 1'b1;
        fu_req_in       = 6'b001000;
        fu_packet_in[3] = mk(3, 5);
        exp_q.push_back(mkexp(3, 5));
        smp();
        cyc();
        fu_packet_in[3] = mk(3, 6);
        exp_q.push_back(mkexp(3, 6));
        smp();
        checks++; if (fu_stall_out[3] !== 1'b0) begin errors++; $display("FAIL reload_stall actual=%0b required=0", fu_stall_out[3]); end
        checks++; if (complete_fu_idx !== 3'd3 || complete_out !== mk(3, 5)) begin errors++; $display("FAIL reload_first actual idx=%0d pkt=%h required idx=3 pkt=%h", complete_fu_idx, complete_out, mk(3, 5)); end
        cyc();
        fu_req_in = '0;
        smp();
        checks++; if (complete_valid !== 1'b1 || complete_out !== mk(3, 6)) begin errors++; $display("FAIL reload_second actual valid=%0b pkt=%h required valid=1 pkt=%h", complete_valid, complete_out, mk(3, 6)); end
        cyc();
        smp();
        checks++; if (complete_valid !== 1'b0 || occupancy_out !== '0) begin errors++; $display("FAIL reload_once actual valid=%0b occ=%0d required valid=0 occ=0", complete_valid, occupancy_out); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reload_left actual=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_flush();
        do_reset();
        fu_req_in       = 6'b010010;
        fu_packet_in[1] = mk(1, 7);
        fu_packet_in[4] = mk(4, 7);
        smp();
        cyc();
        fu_req_in = '0;
        smp();
        checks++; if (occupancy_out !== 3'd2) begin errors++; $display("FAIL flush_pre_occ actual=%0d required=2", occupancy_out); end
        cyc();
        flush           = 1'b1;
        complete_ready  = 1'b1;
        fu_req_in       = 6'b000100;
        fu_packet_in[2] = mk(2, 8);
        smp();
        checks++; if (complete_valid !== 1'b0 || complete_out !== '0 || complete_fu_idx !== '0) begin errors++; $display("FAIL flush_valid actual valid=%0b idx=%0d pkt=%h required valid=0 idx=0 pkt=0", complete_valid, complete_fu_idx, complete_out); end
        cyc();
        flush     = 1'b0;
        fu_req_in = '0;
        smp();
        checks++; if (occupancy_out !== '0) begin errors++; $display("FAIL flush_occ actual=%0d required=0", occupancy_out); end
        cyc();
        smp();
        checks++; if (complete_valid !== 1'b0) begin errors++; $display("FAIL flush_drop actual=%0b required=0", complete_valid); end
    endtask

    task automatic test_alternate();
        localparam int NC = 8;
        do_reset();
        complete_ready = 1'b1;
        for (int k = 1; k <= NC + 1; k++)
            exp_q.push_back(mkexp((k % 2 == 1) ? 0 : 5, 16 + ((k <= 2) ? 0 : k - 2)));
        for (int c = 0; c < NC + 2; c++) begin
            if (c < NC) begin
                fu_req_in       = 6'b100001;
                fu_packet_in[0] = mk(0, 16 + c);
                fu_packet_in[5] = mk(5, 16 + c);
            end else begin
                fu_req_in = '0;
            end
            smp();
            if (c >= 1) begin
                checks++; if (complete_fu_idx !== ((c % 2 == 1) ? 3'd0 : 3'd5)) begin errors++; $display("FAIL alt_idx cycle=%0d actual=%0d required=%0d", c, complete_fu_idx, (c % 2 == 1) ? 0 : 5); end
            end
            cyc();
        end
        smp();
        checks++; if (complete_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL alt_end actual valid=%0b left=%0d required valid=0 left=0", complete_valid, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        complete_ready  = 1'b1;
        fu_req_in       = 6'b010100;
        fu_packet_in[2] = mk(2, 20);
        fu_packet_in[4] = mk(4, 20);
        exp_q.push_back(mkexp(2, 20));
        smp();
        cyc();
        fu_req_in = '0;
        smp();
        checks++; if (complete_fu_idx !== 3'd2) begin errors++; $display("FAIL rmid_first actual=%0d required=2", complete_fu_idx); end
        cyc();
        reset = 1'b0;
        smp();
        checks++; if (complete_valid !== 1'b0 || occupancy_out !== '0 || fu_stall_out !== '0) begin errors++; $display("FAIL rmid_rst actual valid=%0b occ=%0d stall=%b required 0", complete_valid, occupancy_out, fu_stall_out); end
        cyc();
        reset           = 1'b1;
        fu_req_in       = 6'b001010;
        fu_packet_in[1] = mk(1, 21);
        fu_packet_in[3] = mk(3, 21);
        exp_q.push_back(mkexp(1, 21));
        exp_q.push_back(mkexp(3, 21));
        smp();
        cyc();
        fu_req_in = '0;
        smp();
        checks++; if (complete_fu_idx !== 3'd1) begin errors++; $display("FAIL rmid_lowest actual=%0d required=1", complete_fu_idx); end
        cyc();
        smp();
        checks++; if (complete_fu_idx !== 3'd3) begin errors++; $display("FAIL rmid_next actual=%0d required=3", complete_fu_idx); end
        cyc();
        smp();
        checks++; if (complete_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL rmid_end actual valid=%0b left=%0d required valid=0 left=0", complete_valid, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_six();
        test_lock();
        test_reload();
        test_flush();
        test_alternate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/complete_arbiter.md
COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 Parameter NUM_FU, default 6, number of requesting FUs; index 0=ALU_1, 1=ALU_2, 2=ALU_3, 3=MULT_1, 4=MULT_2, 5=BRANCH.
REQ-002 Parameter IDX_W, default $clog2(NUM_FU), width of the grant index.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  mispredict squash; drops all buffered and incoming results.
REQ-006 fu_req_in  input  [NUM_FU-1:0]  FU i presents a finished result.
REQ-007 fu_packet_in  input  FU_COMPLETE_PACKET [NUM_FU-1:0]  result payload per FU.
REQ-008 fu_stall_out  output  [NUM_FU-1:0]  FU i must hold its result and not issue.
REQ-009 complete_ready  input  1  complete stage can accept a packet this cycle.
REQ-010 complete_valid  output  1  complete_out carries a valid packet.
REQ-011 complete_out  output  FU_COMPLETE_PACKET  granted result.
REQ-012 complete_fu_idx  output  IDX_W  index of the granted FU.
REQ-013 occupancy_out  output  $clog2(NUM_FU+1)  count of full holding slots.

Function
REQ-014 One holding slot per FU (full bit + packet); a slot SHALL load when fu_req_in[i] & !fu_stall_out[i] & !flush.
REQ-015 fu_stall_out[i] SHALL equal slot_full[i] & !(transfer & complete_fu_idx==i); transfer = complete_valid & complete_ready.
REQ-016 A result SHALL become eligible for grant the cycle after it is loaded (1-cycle minimum latency, no bypass).
REQ-017 complete_valid SHALL be 1 whenever any slot is full and flush is 0; complete_out/complete_fu_idx SHALL be '0 when complete_valid is 0.
REQ-018 Grant SHALL be round-robin: first full slot at or after rr_ptr, wrapping from NUM_FU-1 to 0.
REQ-019 On transfer, rr_ptr SHALL become (granted index + 1) mod NUM_FU and the granted slot SHALL clear unless reloaded the same cycle.
REQ-020 Simultaneous drain and reload of slot i SHALL leave slot i full with the new packet.
REQ-021 Lock: while complete_valid=1 and complete_ready=0, a LOCKED state SHALL hold complete_fu_idx and complete_out stable, even if a higher-priority slot fills.
REQ-022 Lock states: IDLE (no lock) -> LOCKED on valid & !ready; LOCKED -> IDLE on transfer or flush.
REQ-023 Requests arriving while fu_stall_out[i]=1 SHALL be ignored; the FU holds them.
REQ-024 flush SHALL clear all slots and the lock next edge, force complete_valid=0 in the flush cycle, drop same-cycle requests, and leave rr_ptr unchanged.
REQ-025 occupancy_out SHALL equal popcount of slot full bits (registered state).
REQ-026 No result SHALL be lost or duplicated: each accepted load produces exactly one transfer unless flushed.

Reset
REQ-027 On reset low, asynchronously: all slots empty, packets '0, rr_ptr=0, lock=IDLE.
REQ-028 During reset: complete_valid=0, complete_out='0, complete_fu_idx=0, fu_stall_out=0, occupancy_out=0.
REQ-029 Reset asserted mid-transfer SHALL discard all pending results; first grant after release is the lowest-index full slot.

Structure
REQ-030 FU_COMPLETE_PACKET and the FU index enum SHALL come from the shared sys_defs package; NUM_FU-dependent constants stay local parameters.
REQ-031 The rotating priority picker SHALL be a separate sub-module rr_picker (inputs: req vector, rr_ptr; outputs: grant index, any).

Verification
REQ-032 Reset release, ALU_1 req 1 cycle -> cycle+1 complete_valid=1, idx=0, stall_out all 0.
REQ-033 All 6 req same cycle, ready=1 -> grants idx 0,1,2,3,4,5 in consecutive cycles; stall_out[5] high for 5 cycles.
REQ-034 Slot 2 granted, ready=0 for 3 cycles, slot 0 fills meanwhile -> idx stays 2, packet stable; on ready=1, next grant idx 0 after 3,4,5 empty.
REQ-035 Slot 3 full and granted with ready=1, MULT_1 req same cycle -> slot 3 reloaded, stall_out[3]=0, new packet granted later once.
REQ-036 Slots 1 and 4 full, flush=1 with ALU_3 req -> complete_valid=0 that cycle, occupancy_out=0 next cycle, ALU_3 result dropped.
REQ-037 Continuous req from ALU_1 and BRANCH, ready=1 -> grants alternate 0,5,0,5; neither starves.
